// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, state encodings and datapath select codes for the accumulator CPU sequencer
package cpu_pkg;

    // Opcode field values, instr[7:4]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_LDA  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Accumulator source select
    localparam logic [1:0] ACC_SEL_ALU = 2'd0;
    localparam logic [1:0] ACC_SEL_RF  = 2'd1;
    localparam logic [1:0] ACC_SEL_IMM = 2'd2;

    // ALU operation codes; operands are ACC and rf read_data1
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_instr_decoder.sv
// rtl/cpu_instr_decoder.sv - combinational opcode to control-bundle decoder
module cpu_instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       acc_load,
    output logic [1:0] acc_sel,
    output logic [1:0] alu_op,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_sta,
    output logic       is_halt,
    output logic       is_illegal
);

    // Pure decode of the opcode; select codes stay 0 for ops that do not load ACC
    always_comb begin
        acc_load   = 1'b0;
        acc_sel    = ACC_SEL_ALU;
        alu_op     = ALU_ADD;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_sta     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LDI: begin
                acc_load = 1'b1;
                acc_sel  = ACC_SEL_IMM;
            end
            OP_STA: is_sta = 1'b1;
            OP_LDA: begin
                acc_load = 1'b1;
                acc_sel  = ACC_SEL_RF;
            end
            OP_ADD: begin
                acc_load = 1'b1;
                alu_op   = ALU_ADD;
            end
            OP_SUB: begin
                acc_load = 1'b1;
                alu_op   = ALU_SUB;
            end
            OP_AND: begin
                acc_load = 1'b1;
                alu_op   = ALU_AND;
            end
            OP_OR: begin
                acc_load = 1'b1;
                alu_op   = ALU_OR;
            end
            OP_JMP:  is_jmp  = 1'b1;
            OP_JZ:   is_jz   = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/writeback control FSM for the 8-bit accumulator CPU
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int OPCODE_W = 4,
    parameter int INDEX_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               fetch_req,
    input  logic               fetch_ack,
    input  logic [WORD_W-1:0]  fetch_data,
    input  logic               acc_zero,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [INDEX_W-1:0] rf_raddr1,
    output logic               rf_we,
    output logic [INDEX_W-1:0] rf_waddr,
    output logic               acc_load,
    output logic [1:0]         acc_sel,
    output logic [1:0]         alu_op,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic                acc_zero_q, acc_zero_d;

    logic [OPCODE_W-1:0] opcode;
    logic [INDEX_W-1:0]  index;

    logic                dec_acc_load;
    logic [1:0]          dec_acc_sel;
    logic [1:0]          dec_alu_op;
    logic                dec_is_jmp;
    logic                dec_is_jz;
    logic                dec_is_sta;
    logic                dec_is_halt;
    logic                dec_is_illegal;

    assign opcode = ir_q[WORD_W-1 -: OPCODE_W];
    assign index  = ir_q[INDEX_W-1:0];

    cpu_instr_decoder u_decoder (
        .opcode     (opcode),
        .acc_load   (dec_acc_load),
        .acc_sel    (dec_acc_sel),
        .alu_op     (dec_alu_op),
        .is_jmp     (dec_is_jmp),
        .is_jz      (dec_is_jz),
        .is_sta     (dec_is_sta),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    // State, instruction register and captured zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            acc_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            acc_zero_q <= acc_zero_d;
        end
    end

    // Next-state logic; IR only loads on an ack seen in FETCH.
    // acc_zero is captured on the DECODE->EXEC edge: ACC cannot change between
    // DECODE and EXEC, so this is the EXEC-cycle value while keeping every
    // output a function of registers only.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        acc_zero_d = acc_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_ack) begin
                    ir_d    = fetch_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                acc_zero_d = acc_zero;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_is_halt) begin
                    state_d = ST_HALT;
                end else if (dec_is_sta) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and IR; everything idles at 0 outside its state
    always_comb begin
        fetch_req = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        rf_raddr1 = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        acc_load  = 1'b0;
        acc_sel   = ACC_SEL_ALU;
        alu_op    = ALU_ADD;
        busy      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                busy      = 1'b1;
                fetch_req = 1'b1;
            end
            ST_DECODE: begin
                busy      = 1'b1;
                rf_raddr1 = index;
            end
            ST_EXEC: begin
                busy      = 1'b1;
                rf_raddr1 = index;
                acc_load  = dec_acc_load;
                acc_sel   = dec_acc_sel;
                alu_op    = dec_alu_op;
                illegal   = dec_is_illegal;
                if (dec_is_halt) begin
                    pc_inc = 1'b0;
                end else if (dec_is_jmp) begin
                    pc_load = 1'b1;
                end else if (dec_is_jz) begin
                    pc_load = acc_zero_q;
                    pc_inc  = ~acc_zero_q;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            ST_WB: begin
                busy      = 1'b1;
                rf_raddr1 = index;
                rf_we     = 1'b1;
                rf_waddr  = index;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench: behavioural datapath plus ISA-level reference model
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       fetch_ack = 1'b0;
    logic [7:0] fetch_data = 8'h00;
    logic       acc_zero;
    logic       fetch_req, pc_inc, pc_load, rf_we, acc_load, busy, halted, illegal;
    logic [3:0] rf_raddr1, rf_waddr;
    logic [1:0] acc_sel, alu_op;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fetch_req  (fetch_req),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .acc_zero   (acc_zero),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .rf_raddr1  (rf_raddr1),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .acc_load   (acc_load),
        .acc_sel    (acc_sel),
        .alu_op     (alu_op),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    // Environment: program memory, PC, ACC and register file driven by the DUT controls
    logic [7:0] mem     [256];
    logic [7:0] init_rf [16];
    logic [7:0] dp_rf   [16];
    logic [7:0] dp_pc, dp_acc;

    assign acc_zero = (dp_acc == 8'h00);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_pc  <= 8'h00;
            dp_acc <= 8'h00;
            dp_rf  <= init_rf;
        end else begin
            if (pc_load)     dp_pc <= dp_rf[rf_raddr1];
            else if (pc_inc) dp_pc <= dp_pc + 8'd1;
            if (acc_load) begin
                case ({acc_sel, alu_op})
                    4'b00_00: dp_acc <= dp_acc + dp_rf[rf_raddr1];
                    4'b00_01: dp_acc <= dp_acc - dp_rf[rf_raddr1];
                    4'b00_10: dp_acc <= dp_acc & dp_rf[rf_raddr1];
                    4'b00_11: dp_acc <= dp_acc | dp_rf[rf_raddr1];
                    default:  dp_acc <= (acc_sel == 2'd1) ? dp_rf[rf_raddr1] : {4'h0, rf_raddr1};
                endcase
            end
            if (rf_we) dp_rf[rf_waddr] <= dp_acc;
        end
    end

    // ISA-level reference model
    logic [7:0] m_pc, m_acc;
    logic [7:0] m_rf [16];

    task automatic model_reset();
        m_pc  = 8'h00;
        m_acc = 8'h00;
        m_rf  = init_rf;
    endtask

    task automatic model_step(input logic [7:0] ins, input logic az);
        logic [3:0] op;
        logic [3:0] n;
        op = ins[7:4];
        n  = ins[3:0];
        case (op)
            4'h1: m_acc = {4'h0, n};
            4'h2: m_rf[n] = m_acc;
            4'h3: m_acc = m_rf[n];
            4'h4: m_acc = m_acc + m_rf[n];
            4'h5: m_acc = m_acc - m_rf[n];
            4'h6: m_acc = m_acc & m_rf[n];
            4'h7: m_acc = m_acc | m_rf[n];
            default: ;
        endcase
        if (op == 4'h8 || (op == 4'h9 && az)) m_pc = m_rf[n];
        else if (op != 4'hF)                  m_pc = m_pc + 8'd1;
    endtask

    function automatic logic [19:0] obs();
        return {fetch_req, pc_inc, pc_load, rf_raddr1, rf_we, rf_waddr,
                acc_load, acc_sel, alu_op, busy, halted, illegal};
    endfunction

    function automatic logic [19:0] ev(logic fr, logic inc, logic ld, logic [3:0] ra,
                                       logic we, logic [3:0] wa, logic al, logic [1:0] as,
                                       logic [1:0] ao, logic bz, logic hl, logic il);
        return {fr, inc, ld, ra, we, wa, al, as, ao, bz, hl, il};
    endfunction

    // Expected EXEC-cycle outputs from the opcode table
    function automatic logic [19:0] exec_exp(logic [7:0] ins, logic az);
        logic [3:0] op;
        logic       inc, ld, al, il;
        logic [1:0] as, ao;
        op = ins[7:4];
        inc = 1'b0; ld = 1'b0; al = 1'b0; il = 1'b0; as = 2'd0; ao = 2'd0;
        case (op)
            4'h0, 4'h2: inc = 1'b1;
            4'h1: begin al = 1'b1; as = 2'd2; inc = 1'b1; end
            4'h3: begin al = 1'b1; as = 2'd1; inc = 1'b1; end
            4'h4, 4'h5, 4'h6, 4'h7: begin
                al  = 1'b1;
                ao  = 2'(op - 4'd4);
                inc = 1'b1;
            end
            4'h8: ld = 1'b1;
            4'h9: begin ld = az; inc = !az; end
            4'hF: ;
            default: begin inc = 1'b1; il = 1'b1; end
        endcase
        return ev(1'b0, inc, ld, ins[3:0], 1'b0, 4'h0, al, as, ao, 1'b1, 1'b0, il);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        fetch_ack = 1'b0;
        #1;
        check("reset_now", 32'(obs()), 32'h0);
        tick();
        check("reset_c1", 32'(obs()), 32'h0);
        tick();
        check("reset_c2", 32'(obs()), 32'h0);
        rst_n = 1'b1;
        model_reset();
        tick();
        check("idle", 32'(obs()), 32'h0);
        fetch_ack  = 1'b1;
        fetch_data = 8'($urandom);
        tick();
        check("idle_ack", 32'(obs()), 32'h0);
        fetch_ack = 1'b0;
    endtask

    task automatic start_cpu();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One instruction from its first FETCH cycle through to the next FETCH (or HALT)
    task automatic run_instr(input int dly, input bit kill_wb, output bit done);
        logic [7:0] ins;
        logic       az;
        done      = 1'b0;
        fetch_ack = 1'b0;
        for (int i = 0; i < dly; i++) begin
            check("fetch_wait", 32'(obs()), 32'(ev(1, 0, 0, 4'h0, 0, 4'h0, 0, 2'd0, 2'd0, 1, 0, 0)));
            fetch_data = 8'($urandom);
            tick();
        end
        check("fetch", 32'(obs()), 32'(ev(1, 0, 0, 4'h0, 0, 4'h0, 0, 2'd0, 2'd0, 1, 0, 0)));
        ins        = mem[m_pc];
        fetch_ack  = 1'b1;
        fetch_data = ins;
        tick();
        fetch_ack  = 1'($urandom);
        fetch_data = 8'($urandom);
        check("decode", 32'(obs()), 32'(ev(0, 0, 0, ins[3:0], 0, 4'h0, 0, 2'd0, 2'd0, 1, 0, 0)));
        tick();
        az = (m_acc == 8'h00);
        check("exec", 32'(obs()), 32'(exec_exp(ins, az)));
        check("exclusive", 32'({pc_inc & pc_load, acc_load & rf_we}), 32'h0);
        tick();
        if (ins[7:4] == 4'h2) begin
            check("wb", 32'(obs()), 32'(ev(0, 0, 0, ins[3:0], 1, ins[3:0], 0, 2'd0, 2'd0, 1, 0, 0)));
            if (kill_wb) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_wb", 32'(obs()), 32'h0);
                model_reset();
                done = 1'b1;
                return;
            end
            tick();
        end
        fetch_ack = 1'b0;
        model_step(ins, az);
        if (ins[7:4] == 4'hF) begin
            check("halt", 32'(obs()), 32'(ev(0, 0, 0, 4'h0, 0, 4'h0, 0, 2'd0, 2'd0, 0, 1, 0)));
            done = 1'b1;
        end else begin
            check("arch_pc", 32'(dp_pc), 32'(m_pc));
            check("arch_acc", 32'(dp_acc), 32'(m_acc));
            if (ins[7:4] == 4'h2) check("arch_rf", 32'(dp_rf[ins[3:0]]), 32'(m_rf[ins[3:0]]));
        end
    endtask

    initial begin
        bit done;
        logic [7:0] directed [8];
        int         dlys     [8];

        // Directed program: LDI 7, STA R2, SUB R2 (slow ack), JZ R5 taken,
        // LDI 3, JZ R5 not taken, illegal, HALT
        directed = '{8'h17, 8'h22, 8'h52, 8'h95, 8'h13, 8'h95, 8'hB0, 8'hF0};
        dlys     = '{0, 0, 3, 0, 0, 1, 0, 0};
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        for (int i = 0; i < 8; i++)   mem[i] = directed[i];
        for (int i = 0; i < 16; i++)  init_rf[i] = 8'($urandom);
        init_rf[5] = 8'd4;
        do_reset();
        start_cpu();
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) run_instr(dlys[i], 1'b0, done);
        check("directed_halted", 32'(done), 32'd1);

        // HALT absorbs start and ack
        for (int i = 0; i < 4; i++) begin
            start      = 1'b1;
            fetch_ack  = 1'b1;
            fetch_data = 8'($urandom);
            tick();
            check("halt_hold", 32'(obs()), 32'(ev(0, 0, 0, 4'h0, 0, 4'h0, 0, 2'd0, 2'd0, 0, 1, 0)));
        end
        start     = 1'b0;
        fetch_ack = 1'b0;

        // Random programs; unfinished ones are cut by a mid-run reset
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < 16; i++)  init_rf[i] = 8'($urandom);
            do_reset();
            start_cpu();
            done = 1'b0;
            for (int i = 0; i < 40 && !done; i++) run_instr(int'($urandom_range(0, 3)), 1'b0, done);
        end

        // Reset asserted during the WB of an STA
        mem[0] = 8'h1A;
        mem[1] = 8'h23;
        do_reset();
        start_cpu();
        run_instr(0, 1'b0, done);
        run_instr(1, 1'b1, done);
        check("wb_killed", 32'(done), 32'd1);
        do_reset();
        check("post_kill_rf", 32'(dp_rf[3]), 32'(init_rf[3]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
